fpu_op_sequencer: RTL and testbench

// Two-requester front end for the shared fp16 add/sub/mul datapath. It takes

---
 rtl/fpu_op_sequencer_if.sv | 32 +++
 rtl/fpu_op_sequencer.sv | 172 +++++++++++++++++
 tb/tb_fpu_op_sequencer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_op_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_op_sequencer_if
//  Description : Request/response bundle between two requesters and the
//                fp16 op sequencer. Index [n] belongs to requester n.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fpu_op_sequencer_if;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][1:0]  req_op;
    logic [1:0][15:0] req_a;
    logic [1:0][15:0] req_b;
    logic [1:0]       resp_valid;
    logic [1:0]       resp_ready;
    logic [15:0]      resp_result;
    logic [2:0]       resp_flags;
    logic             resp_illegal;

    // Requester side
    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_flags, resp_illegal
    );

    // Sequencer side
    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_result, resp_flags, resp_illegal
    );
endinterface
`default_nettype wire

// File: rtl/fpu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_op_sequencer
//  Description : Round-robin front end for the shared fp16 add/sub/mul
//                datapath. Holds operands for DP_LAT cycles, captures the
//                result and {OF,UF,NX}, returns them to the owning requester
//                and accumulates architectural sticky flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_op_sequencer #(
    parameter int DP_LAT = 2            // 1..15
) (
    input  wire               clk,
    input  wire               rst,
    fpu_op_sequencer_if.slave bus,
    output logic              dp_start_o,
    output logic [1:0]        dp_op_o,
    output logic [15:0]       dp_a_o,
    output logic [15:0]       dp_b_o,
    input  wire  [15:0]       dp_result_i,
    input  wire  [2:0]        dp_flags_i,
    output logic [2:0]        sticky_flags_o,
    input  wire               sticky_clr_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [15:0] c_ILLEGAL_NAN = 16'h7E00;
    localparam logic [3:0]  c_CNT_LOAD    = 4'(DP_LAT - 1);

    state_t      state_q, state_d;
    logic        prio_q, prio_d;
    logic        owner_q, owner_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [3:0]  count_q, count_d;
    logic        start_q, start_d;
    logic [15:0] result_q, result_d;
    logic [2:0]  flags_q, flags_d;
    logic        illegal_q, illegal_d;
    logic [2:0]  sticky_q, sticky_d;

    logic        w_gnt_idx;
    logic        w_accept;
    logic        w_capture;

    // Arbitration: priority requester wins if valid, else the other one
    always_comb begin
        w_gnt_idx     = bus.req_valid[prio_q] ? prio_q : ~prio_q;
        w_accept      = (state_q == S_IDLE) && (|bus.req_valid);
        bus.req_ready = 2'b00;
        if (w_accept) begin
            bus.req_ready[w_gnt_idx] = 1'b1;
        end
    end

    // Next-state logic; operand latches only move on an accept
    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        owner_d   = owner_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        count_d   = count_q;
        start_d   = 1'b0;
        result_d  = result_q;
        flags_d   = flags_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    owner_d = w_gnt_idx;
                    prio_d  = ~w_gnt_idx;
                    op_d    = bus.req_op[w_gnt_idx];
                    a_d     = bus.req_a[w_gnt_idx];
                    b_d     = bus.req_b[w_gnt_idx];
                    if (bus.req_op[w_gnt_idx] == 2'b11) begin
                        // Illegal opcode never touches the datapath
                        result_d  = c_ILLEGAL_NAN;
                        flags_d   = 3'b000;
                        illegal_d = 1'b1;
                        state_d   = S_RESP;
                    end else begin
                        start_d   = 1'b1;
                        count_d   = c_CNT_LOAD;
                        illegal_d = 1'b0;
                        state_d   = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (count_q == 4'd0) begin
                    result_d = dp_result_i;
                    flags_d  = dp_flags_i;
                    state_d  = S_RESP;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            S_RESP: begin
                if (bus.resp_ready[owner_q]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sticky flags: a clear coinciding with a capture keeps that op's flags
    always_comb begin
        w_capture = (state_q == S_EXEC) && (count_q == 4'd0);
        sticky_d  = (sticky_clr_i ? 3'b000 : sticky_q) |
                    (w_capture ? dp_flags_i : 3'b000);
    end

    // State and datapath registers; reset drops any in-flight op
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            prio_q    <= 1'b0;
            owner_q   <= 1'b0;
            op_q      <= 2'b00;
            a_q       <= 16'h0000;
            b_q       <= 16'h0000;
            count_q   <= 4'd0;
            start_q   <= 1'b0;
            result_q  <= 16'h0000;
            flags_q   <= 3'b000;
            illegal_q <= 1'b0;
            sticky_q  <= 3'b000;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            owner_q   <= owner_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            count_q   <= count_d;
            start_q   <= start_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
            illegal_q <= illegal_d;
            sticky_q  <= sticky_d;
        end
    end

    // Output drive
    always_comb begin
        bus.resp_valid       = 2'b00;
        if (state_q == S_RESP) begin
            bus.resp_valid[owner_q] = 1'b1;
        end
        bus.resp_result  = result_q;
        bus.resp_flags   = flags_q;
        bus.resp_illegal = illegal_q;
        dp_start_o       = start_q;
        dp_op_o          = op_q;
        dp_a_o           = a_q;
        dp_b_o           = b_q;
        sticky_flags_o   = sticky_q;
        busy_o           = (state_q != S_IDLE);
    end

endmodule
`default_nettype wire

// File: tb/tb_fpu_op_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fpu_op_sequencer
//  Description : Directed plus randomized bench for fpu_op_sequencer with a
//                transaction-level reference model and a datapath stand-in.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_op_sequencer;
    localparam int DP_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        dp_start;
    logic [1:0]  dp_op;
    logic [15:0] dp_a, dp_b, dp_result;
    logic [2:0]  dp_flags, sticky;
    logic        sticky_clr, busy;

    fpu_op_sequencer_if bus();

    fpu_op_sequencer #(.DP_LAT(DP_LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .dp_start_o    (dp_start),
        .dp_op_o       (dp_op),
        .dp_a_o        (dp_a),
        .dp_b_o        (dp_b),
        .dp_result_i   (dp_result),
        .dp_flags_i    (dp_flags),
        .sticky_flags_o(sticky),
        .sticky_clr_i  (sticky_clr),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    int         pass_cnt = 0;
    int         fail_cnt = 0;
    int         total    = 0;
    logic       prio_m;
    logic [2:0] sticky_m;
    int         since = 100;

    // Stand-in arithmetic: any deterministic function of the operands will do
    function automatic logic [15:0] ref_result(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            2'b00:   return a + b - 16'h3800;
            2'b01:   return a - b;
            default: return a ^ {b[7:0], b[15:8]};
        endcase
    endfunction

    function automatic logic [2:0] ref_flags(input logic [15:0] a, input logic [15:0] b);
        return a[2:0] ^ b[2:0];
    endfunction

    function automatic logic [1:0] exp_grant(input logic [1:0] v, input logic p);
        if (v[p])  return 2'b01 << p;
        if (v[!p]) return 2'b01 << (!p);
        return 2'b00;
    endfunction

    // Datapath stand-in: answer is only valid DP_LAT-1 cycles after dp_start
    always_ff @(posedge clk) since <= dp_start ? 1 : ((since < 100) ? since + 1 : since);

    always_comb begin
        dp_result = 16'hDEAD;
        dp_flags  = 3'b111;
        if ((DP_LAT == 1) ? dp_start : (since == DP_LAT - 1)) begin
            dp_result = ref_result(dp_op, dp_a, dp_b);
            dp_flags  = ref_flags(dp_a, dp_b);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_req(input int r);
        bus.req_op[r] = 2'($urandom_range(0, 3));
        bus.req_a[r]  = 16'($urandom);
        bus.req_b[r]  = 16'($urandom);
    endtask

    // Waits for an accept cycle and checks the grant against the model
    task automatic wait_grant(output int g);
        logic       ok;
        logic [1:0] expg;
        ok = 1'b0;
        g  = 0;
        for (int k = 0; k < 30 && !ok; k++) begin
            @(negedge clk);
            ok = (bus.req_ready != 2'b00);
        end
        chk("grant_seen", 32'(ok), 32'd1);
        expg = exp_grant(bus.req_valid, prio_m);
        chk("grant", 32'(bus.req_ready), 32'(expg));
        g      = expg[1] ? 1 : 0;
        prio_m = (g == 0);
    endtask

    // Follows one op from its accept cycle through the response
    task automatic finish_op(input int g, input bit drop, input int hold, input int clr_cyc);
        logic [1:0]  op;
        logic [15:0] a, b, exp_r;
        logic [2:0]  exp_f;
        logic        exp_ill, seen, dp_ok;
        int          lat, starts, start_at;
        op = bus.req_op[g]; a = bus.req_a[g]; b = bus.req_b[g];
        exp_ill = (op == 2'b11);
        exp_r   = exp_ill ? 16'h7E00 : ref_result(op, a, b);
        exp_f   = exp_ill ? 3'b000 : ref_flags(a, b);
        seen = 1'b0; dp_ok = 1'b1; lat = 0; starts = 0; start_at = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                if (drop) bus.req_valid[g] = 1'b0;
                else      rand_req(g);
            end
            sticky_clr = (clr_cyc != 0) && (k + 1 == clr_cyc);
            @(negedge clk);
            lat++;
            if (dp_start) begin starts++; start_at = lat; end
            if (!exp_ill && lat <= DP_LAT)
                dp_ok = dp_ok && (dp_a === a) && (dp_b === b) && (dp_op === op) && (bus.req_ready === 2'b00);
            seen = (bus.resp_valid != 2'b00);
        end
        sticky_clr = 1'b0;
        chk("resp_seen", 32'(seen), 32'd1);
        chk("latency", lat, exp_ill ? 1 : DP_LAT + 1);
        chk("dp_start_count", starts, exp_ill ? 0 : 1);
        chk("dp_start_cycle", start_at, exp_ill ? 0 : 1);
        if (!exp_ill) chk("dp_operands_stable", 32'(dp_ok), 32'd1);
        chk("resp_valid", 32'(bus.resp_valid), 32'd1 << g);
        chk("resp_result", 32'(bus.resp_result), 32'(exp_r));
        chk("resp_flags", 32'(bus.resp_flags), 32'(exp_f));
        chk("resp_illegal", 32'(bus.resp_illegal), 32'(exp_ill));
        if (!exp_ill) begin
            if (clr_cyc == DP_LAT) sticky_m = 3'b000;
            sticky_m = sticky_m | exp_f;
        end
        chk("sticky", 32'(sticky), 32'(sticky_m));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_resp_valid", 32'(bus.resp_valid), 32'd1 << g);
            chk("hold_result", 32'(bus.resp_result), 32'(exp_r));
            chk("hold_flags", 32'(bus.resp_flags), 32'(exp_f));
            chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
            chk("hold_dp_a", 32'(dp_a), 32'(a));
        end
        if (hold > 0) begin
            @(posedge clk); #1;
            bus.resp_ready[g] = 1'b1;
            @(negedge clk);
            chk("release_resp_valid", 32'(bus.resp_valid), 32'd1 << g);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int g;
        int cnt[2];
        logic any_resp;
        rst = 1'b1; sticky_clr = 1'b0;
        bus.req_valid = '0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
        bus.resp_ready = '0;
        prio_m = 1'b0; sticky_m = 3'b000;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dp_start", 32'(dp_start), 32'd0);
        chk("rst_dp_a", 32'(dp_a), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_sticky", 32'(sticky), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed add 3C00+3C00 from requester 0
        bus.resp_ready = 2'b01;
        bus.req_op[0] = 2'b00; bus.req_a[0] = 16'h3C00; bus.req_b[0] = 16'h3C00;
        bus.req_valid = 2'b01;
        wait_grant(g);
        finish_op(g, 1'b1, 0, 0);
        chk("first_result_4000", 32'(bus.resp_result), 32'h4000);

        // Both requesters always valid: grants must alternate
        bus.resp_ready = 2'b11;
        rand_req(0); rand_req(1);
        bus.req_valid = 2'b11;
        cnt[0] = 0; cnt[1] = 0;
        for (int i = 0; i < 8; i++) begin
            wait_grant(g);
            cnt[g]++;
            finish_op(g, 1'b0, 0, 0);
        end
        bus.req_valid = 2'b00;
        chk("rr_count0", cnt[0], 4);
        chk("rr_count1", cnt[1], 4);

        // Illegal opcode from requester 1
        bus.req_op[1] = 2'b11; bus.req_a[1] = 16'h1234; bus.req_b[1] = 16'h5678;
        bus.req_valid = 2'b10;
        wait_grant(g);
        finish_op(g, 1'b1, 0, 0);

        // Back-pressure: owner not ready for 5 cycles, non-owner ready ignored
        bus.resp_ready = 2'b10;
        bus.req_op[0] = 2'b01; bus.req_a[0] = 16'h4A5B; bus.req_b[0] = 16'h1357;
        bus.req_op[1] = 2'b00;
        bus.req_valid = 2'b11;
        wait_grant(g);
        finish_op(g, 1'b1, 5, 0);
        bus.req_valid = 2'b00;
        bus.resp_ready = 2'b11;

        // Sticky clear coinciding with a capture keeps the new flags
        @(posedge clk); #1; sticky_clr = 1'b1;
        @(posedge clk); #1; sticky_clr = 1'b0;
        sticky_m = 3'b000;
        @(negedge clk);
        chk("sticky_cleared", 32'(sticky), 32'd0);
        bus.req_op[0] = 2'b00; bus.req_a[0] = 16'h0003; bus.req_b[0] = 16'h0000;
        bus.req_valid = 2'b01;
        wait_grant(g);
        finish_op(g, 1'b1, 0, 0);
        chk("sticky_011", 32'(sticky), 32'b011);
        bus.req_op[0] = 2'b00; bus.req_a[0] = 16'h0004; bus.req_b[0] = 16'h0000;
        bus.req_valid = 2'b01;
        wait_grant(g);
        finish_op(g, 1'b1, 0, DP_LAT);
        chk("sticky_clr_capture", 32'(sticky), 32'b100);

        // Asynchronous reset in the second EXEC cycle
        rand_req(0);
        bus.req_op[0] = 2'b10;
        bus.req_valid = 2'b01;
        wait_grant(g);
        @(posedge clk); #1; bus.req_valid = 2'b00;
        @(posedge clk); #1; rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_dp_start", 32'(dp_start), 32'd0);
        chk("arst_dp_ab", 32'({dp_a, dp_b}), 32'd0);
        chk("arst_dp_op", 32'(dp_op), 32'd0);
        chk("arst_result", 32'(bus.resp_result), 32'd0);
        chk("arst_sticky", 32'(sticky), 32'd0);
        any_resp = 1'b0;
        repeat (3) begin
            @(negedge clk);
            any_resp = any_resp | (|bus.resp_valid) | busy;
        end
        chk("arst_no_resp", 32'(any_resp), 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        prio_m = 1'b0; sticky_m = 3'b000;
        rand_req(0); rand_req(1);
        bus.req_op[0] = 2'b00;
        bus.req_valid = 2'b11;
        wait_grant(g);
        finish_op(g, 1'b1, 0, 0);
        bus.req_valid = 2'b00;
        @(posedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
`default_nettype wire
